// File: rtl/wb_unit_pkg.sv
// Shared constants and types for the writeback stage.
// Holds datapath widths, the opcode/funct encodings the stage decodes, the link
// register address, the FSM state type, and a load-opcode classifier.
package wb_unit_pkg;

    localparam int unsigned WordWidth    = 32;
    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned OpcodeWidth  = 6;
    localparam int unsigned FunctWidth   = 6;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpLb    = 6'h20;
    localparam logic [5:0] OpLh    = 6'h21;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpLbu   = 6'h24;
    localparam logic [5:0] OpLhu   = 6'h25;

    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnJalr  = 6'h09;

    localparam logic [4:0] LinkReg = 5'd31;

    typedef enum logic [0:0] {
        StIdle,
        StWaitLoad
    } wb_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) || (op == OpLhu);
    endfunction

endpackage

// File: rtl/wb_unit_load_extend.sv
// Load data extraction for the writeback stage.
// Ports: word   - aligned word returned by data memory
//        offset - byte offset (address bits [1:0]) latched at accept
//        opcode - load opcode latched at accept
//        data   - selected byte/halfword/word, sign- or zero-extended
// Purely combinational; little-endian lane selection.
module wb_unit_load_extend #(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned OPCODE_WIDTH = 6
) (
    input  logic [WORD_WIDTH-1:0]   word,
    input  logic [1:0]              offset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [WORD_WIDTH-1:0]   data
);
    import wb_unit_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        unique case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (opcode)
            OpLb:    data = {{(WORD_WIDTH-8){byte_sel[7]}}, byte_sel};
            OpLbu:   data = {{(WORD_WIDTH-8){1'b0}}, byte_sel};
            OpLh:    data = {{(WORD_WIDTH-16){half_sel[15]}}, half_sel};
            OpLhu:   data = {{(WORD_WIDTH-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: write side of the register file.
// Ports: clk/rst_n                 - clock, async active-low reset
//        in_valid/in_ready         - handshake with the MEM stage
//        opcode/funct/rt/rd        - instruction fields of the retiring op
//        alu_result/pc_plus8       - result sources (alu_result is the address for loads)
//        mem_rvalid/mem_rdata      - load data return (one-cycle pulse)
//        wrt_dt/wrt_reg/reg_wrt    - registered register-file write port
//        retired                   - completed-instruction count (wraps)
//        err_rvalid/err_timeout    - sticky protocol-fault flags
module wb_unit #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned REGADDR_WIDTH = 5,
    parameter int unsigned OPCODE_WIDTH  = 6,
    parameter int unsigned FUNCT_WIDTH   = 6,
    parameter int unsigned LOAD_TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_WIDTH-1:0]  opcode,
    input  logic [FUNCT_WIDTH-1:0]   funct,
    input  logic [REGADDR_WIDTH-1:0] rt,
    input  logic [REGADDR_WIDTH-1:0] rd,
    input  logic [WORD_WIDTH-1:0]    alu_result,
    input  logic [WORD_WIDTH-1:0]    pc_plus8,
    input  logic                     mem_rvalid,
    input  logic [WORD_WIDTH-1:0]    mem_rdata,
    output logic [WORD_WIDTH-1:0]    wrt_dt,
    output logic [REGADDR_WIDTH-1:0] wrt_reg,
    output logic                     reg_wrt,
    output logic [31:0]              retired,
    output logic                     err_rvalid,
    output logic                     err_timeout
);
    import wb_unit_pkg::*;

    localparam logic [7:0] TmoLimit = 8'(LOAD_TIMEOUT);

    wb_state_e                state_q;
    logic [7:0]               tmo_cnt_q;
    logic [OPCODE_WIDTH-1:0]  ld_op_q;
    logic [1:0]               ld_off_q;
    logic [REGADDR_WIDTH-1:0] ld_dst_q;
    logic [WORD_WIDTH-1:0]    wrt_dt_q;
    logic [REGADDR_WIDTH-1:0] wrt_reg_q;
    logic                     reg_wrt_q;
    logic [31:0]              retired_q;
    logic                     err_rvalid_q;
    logic                     err_timeout_q;

    logic                     dec_we;
    logic                     dec_load;
    logic [REGADDR_WIDTH-1:0] dec_dst;
    logic [WORD_WIDTH-1:0]    dec_data;
    logic [WORD_WIDTH-1:0]    ld_data;

    // Decode of the instruction presented at the input.
    always_comb begin
        dec_we   = 1'b0;
        dec_load = 1'b0;
        dec_dst  = rd;
        dec_data = alu_result;
        if (opcode == OpRtype) begin
            if (funct == FnJalr) begin
                dec_we   = 1'b1;
                dec_data = pc_plus8;
            end else if (funct != FnJr) begin
                dec_we = 1'b1;
            end
        end else if (opcode == OpJal) begin
            dec_we   = 1'b1;
            dec_dst  = LinkReg;
            dec_data = pc_plus8;
        end else if (opcode[5:3] == 3'b001) begin
            // ADDI..LUI occupy 0x08-0x0F
            dec_we  = 1'b1;
            dec_dst = rt;
        end else if (is_load(opcode)) begin
            dec_load = 1'b1;
            dec_dst  = rt;
        end
    end

    wb_unit_load_extend #(
        .WORD_WIDTH  (WORD_WIDTH),
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_load_extend (
        .word  (mem_rdata),
        .offset(ld_off_q),
        .opcode(ld_op_q),
        .data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tmo_cnt_q     <= '0;
            ld_op_q       <= '0;
            ld_off_q      <= '0;
            ld_dst_q      <= '0;
            wrt_dt_q      <= '0;
            wrt_reg_q     <= '0;
            reg_wrt_q     <= 1'b0;
            retired_q     <= '0;
            err_rvalid_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            reg_wrt_q <= 1'b0;
            // Load data outside WAIT_LOAD is dropped, even on a load's accept edge.
            if (mem_rvalid && (state_q == StIdle)) begin
                err_rvalid_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (dec_load) begin
                            state_q   <= StWaitLoad;
                            tmo_cnt_q <= '0;
                            ld_op_q   <= opcode;
                            ld_off_q  <= alu_result[1:0];
                            ld_dst_q  <= dec_dst;
                        end else begin
                            retired_q <= retired_q + 32'd1;
                            if (dec_we && (dec_dst != '0)) begin
                                reg_wrt_q <= 1'b1;
                                wrt_reg_q <= dec_dst;
                                wrt_dt_q  <= dec_data;
                            end
                        end
                    end
                end
                StWaitLoad: begin
                    // Data arriving on the final timeout cycle still completes the load.
                    if (mem_rvalid) begin
                        state_q   <= StIdle;
                        retired_q <= retired_q + 32'd1;
                        if (ld_dst_q != '0) begin
                            reg_wrt_q <= 1'b1;
                            wrt_reg_q <= ld_dst_q;
                            wrt_dt_q  <= ld_data;
                        end
                    end else if ((tmo_cnt_q + 8'd1) == TmoLimit) begin
                        state_q       <= StIdle;
                        tmo_cnt_q     <= tmo_cnt_q + 8'd1;
                        err_timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign wrt_dt      = wrt_dt_q;
    assign wrt_reg     = wrt_reg_q;
    assign reg_wrt     = reg_wrt_q;
    assign retired     = retired_q;
    assign err_rvalid  = err_rvalid_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback stage for the MIPS-subset pipeline: the write side of the decode-stage register file. Accepts retired instructions from the MEM stage with a valid/ready handshake, selects the destination register and result (ALU result, extended load data, or link address), waits for load data from data memory, and drives the register file write port (`wrt_dt`, `wrt_reg`, `reg_wrt`) from registers. Also counts retired instructions and flags protocol faults.

## Interface
- `WORD_WIDTH`, 32, datapath width (from `defines.v`)
- `REGADDR_WIDTH`, 5, register address width
- `OPCODE_WIDTH`, 6, opcode field width
- `FUNCT_WIDTH`, 6, funct field width
- `LOAD_TIMEOUT`, 255, max cycles in WAIT_LOAD before abandoning the load (1..255)

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  MEM stage presents an instruction
- `in_ready`  out  1  unit can accept (combinational from state)
- `opcode`  in  OPCODE_WIDTH  instruction opcode
- `funct`  in  FUNCT_WIDTH  instruction funct
- `rt`, `rd`  in  REGADDR_WIDTH  register fields
- `alu_result`  in  WORD_WIDTH  ALU result; for loads, byte address
- `pc_plus8`  in  WORD_WIDTH  link value
- `mem_rvalid`  in  1  load data valid, one-cycle pulse
- `mem_rdata`  in  WORD_WIDTH  aligned load word
- `wrt_dt`  out  WORD_WIDTH  write data
- `wrt_reg`  out  REGADDR_WIDTH  write register
- `reg_wrt`  out  1  write enable, one-cycle pulse
- `retired`  out  32  retired-instruction count, wraps
- `err_rvalid`  out  1  sticky: `mem_rvalid` outside WAIT_LOAD
- `err_timeout`  out  1  sticky: load timed out

## Operation
- Accept when `in_valid && in_ready`. `in_ready` = 1 in IDLE, 0 in WAIT_LOAD.
- Decode on accept (opcode hex): 00 R-type → dest `rd`, data `alu_result`; except funct 08 (JR) → no write, funct 09 (JALR) → dest `rd`, data `pc_plus8`. 03 (JAL) → dest 31, data `pc_plus8`. 08–0F (ADDI..LUI) → dest `rt`, data `alu_result`. 20 LB, 21 LH, 23 LW, 24 LBU, 25 LHU → load to `rt`. All other opcodes → no write.
- Load extraction uses `alu_result[1:0]` latched at accept, little-endian: LB/LBU byte `[8*k+7:8*k]`, LH/LHU halfword `k[1]`, LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
- Destination 0 never written (`reg_wrt` stays 0), but still retires.
- FSM: IDLE --accept load--> WAIT_LOAD; WAIT_LOAD --`mem_rvalid`--> IDLE with write; WAIT_LOAD --counter reaches LOAD_TIMEOUT--> IDLE, no write, set `err_timeout`, no retire.
- `mem_rvalid` in IDLE is ignored and sets `err_rvalid`, including in the accept cycle of a load.
- `retired` increments once per completed instruction: non-load at accept, load at data capture.

## Timing
- Reset: state IDLE, `wrt_dt`=0, `wrt_reg`=0, `reg_wrt`=0, `retired`=0, both error flags 0, timeout counter 0. Reset mid-load abandons the load and emits no write.
- Non-load accepted at edge N → `reg_wrt`/`wrt_reg`/`wrt_dt` valid for cycle N..N+1 (one cycle). Back-to-back accepts give back-to-back pulses.
- Load accepted at edge N → WAIT_LOAD from N; `mem_rvalid` sampled at edge M>N → write pulse in cycle after M; `in_ready` returns high in that same cycle.
- Timeout counter clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle; exit occurs at the edge where count equals LOAD_TIMEOUT.
- `wrt_dt`/`wrt_reg` hold their last value when `reg_wrt`=0.

## Structure
- Opcode/funct constants, field widths, and register 31 link address go in `defines.v`.
- Sub-module `load_extend`: combinational byte/halfword select plus sign/zero extension (inputs: word, offset, opcode).

## Test plan
- Reset then ADDI `rt`=5, `alu_result`=0x0000_0007 → `reg_wrt` pulse, `wrt_reg`=5, `wrt_dt`=0x7, `retired`=1.
- LB `rt`=9, addr low bits 2'b10, `mem_rvalid` 3 cycles later with 0x1280_FF34 → `in_ready` 0 for 3 cycles, then write 0xFFFF_FF80 to r9.
- JAL `pc_plus8`=0x0040_0010 followed by JR → one write of 0x0040_0010 to r31, JR no write, `retired`=2.
- R-type ADD with `rd`=0 → no `reg_wrt`, `retired` increments.
- LW with no `mem_rvalid`, `LOAD_TIMEOUT`=4 → `err_timeout`=1 after 4 cycles, no write, `in_ready` back to 1.
- `mem_rvalid` pulse in IDLE → `err_rvalid`=1, outputs unchanged; assert `rst_n` low during WAIT_LOAD → all outputs zero, IDLE.
